evalpost_fmt: RTL
=================

Name: evalpost_fmt

Overview:
- Result formatter: the output-side counterpart of the infix evaluator.
- Takes the evaluator's signed N-bit result and overflow flag and renders them as an ASCII decimal string.
- The string is delivered two ways: as a valid/ready byte stream, and as a packed, left-justified, NUL-padded string in the same layout the evaluator consumes (first character in the most significant byte).
- Sits after evalpost and feeds the UART/console path and the self-checking bench.

Parameters:
- N, 16: width of the signed result being formatted.
- LEN, 8: packed output string length in characters; must satisfy LEN >= DIG+1.
- DIG, (N+2)/3: number of BCD digits held internally (localparam, not overridable); 6 for N=16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to format value/ovf_in; accepted only in IDLE.
- value  in  N  signed result to format; sampled when start is accepted.
- ovf_in  in  1  overflow flag; sampled with value.
- busy  out  1  high from the cycle after acceptance until done.
- tx_data  out  8  current ASCII character.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both high.
- tx_last  out  1  marks the final character of the string.
- str  out  8*LEN  packed result string, left-justified, NUL ('\0') padded.
- done  out  1  one-cycle pulse after the last byte handshake.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - busy, tx_valid, tx_last, done = 0.
  - tx_data = 8'h00; str = all zeros.
  - Internal BCD, shift and character registers cleared.
  - Reset mid-conversion or mid-emit aborts immediately. No partial string is kept: str clears and done does not fire.
- Start acceptance and capture:
  - IDLE: start=1 is accepted and the next state is CONV; start while busy is ignored.
  - On acceptance: capture ovf_in; neg = value[N-1]; mag = |value| held in N+1 bits, so the most negative value (-32768 for N=16) converts correctly.
  - Clear the BCD register (DIG x 4 bits) and clear str.
- CONV:
  - Double-dabble, exactly N cycles, one bit of mag per cycle MSB first.
  - Each cycle, add 3 to every BCD nibble >= 5, then shift left by 1, bringing in the next mag bit.
  - If the captured overflow flag is 1, CONV is skipped: the next state is EMIT with the fixed string "OVF".
- EMIT character order:
  - '-' if neg (and no overflow).
  - Then digits from the most significant nonzero BCD nibble downward, each as 8'h30+nibble.
  - Value 0 emits the single character "0".
  - Leading zeros are never emitted.
- EMIT handshake:
  - tx_valid is asserted the first cycle in EMIT.
  - tx_data/tx_last hold stable while tx_valid=1 and tx_ready=0.
  - The pointer advances only on a handshake; one byte per cycle maximum when tx_ready is held high.
  - tx_last=1 together with the final character.
- str build: each handshaken character is written into str at the next position from the MSB end, so str always holds the characters emitted so far followed by NULs.
- Completion:
  - After the tx_last handshake: tx_valid=0, busy=0, done=1 for one cycle, state returns to IDLE.
  - str holds its value until the next accepted start or reset.
- Latency: with tx_ready held high, the first tx_valid appears 1+N cycles after start (1 cycle for OVF). A k-character string needs k further cycles.
- Arithmetic: no saturation or truncation. DIG is always sufficient because 2^N <= 10^DIG.

Test Plan:
- value=0, tx_ready=1 -> bytes "0"; tx_last on byte 1; str="0" then 7 NULs; first tx_valid 17 cycles after start; done one cycle after the handshake.
- value=-7300 -> "-7300": 5 bytes, tx_last on the final '0'. Then value=32767 -> "32767". Internal zeros are kept while leading zeros are suppressed.
- value=16'h8000 (-32768) -> "-32768", 6 bytes; verifies the N+1-bit magnitude path.
- ovf_in=1 with value=123 -> "OVF"; first tx_valid 1 cycle after start; digits of 123 never emitted.
- Backpressure on value=-42:
  - Drop tx_ready for 5 cycles after the '-' is presented -> '-' and tx_valid held stable.
  - Then "-42" completes with no lost or duplicated byte.
  - A start pulsed during busy is ignored, and str ends as "-42".
- Reset mid-operation:
  - Assert rst_n=0 during EMIT of 12345 after 2 handshakes -> outputs zero asynchronously and done never pulses.
  - After release, start with 9 -> "9" correctly.

Source files
------------

// File: rtl/evalpost_fmt_if.sv
// evalpost_fmt_if: start/value request side and byte-stream/packed-string result side of the formatter
interface evalpost_fmt_if #(parameter int N = 16, parameter int LEN = 8);
   logic             start;
   logic [N-1:0]     value;
   logic             ovf_in;
   logic             busy;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             tx_last;
   logic [8*LEN-1:0] str;
   logic             done;
   modport master (output start, value, ovf_in, tx_ready,
                   input busy, tx_data, tx_valid, tx_last, str, done);
   modport slave (input start, value, ovf_in, tx_ready,
                  output busy, tx_data, tx_valid, tx_last, str, done);
endinterface

// File: rtl/evalpost_fmt.sv
// evalpost_fmt: renders a signed result (or overflow) as ASCII decimal, streamed byte by byte
// and accumulated into a left-justified NUL-padded packed string.
module evalpost_fmt #(parameter int N = 16, parameter int LEN = 8) (
   input logic          clk,
   input logic          rst_n,
   evalpost_fmt_if.slave bus
);
   localparam int DIG = (N + 2) / 3;
   localparam int PW = $clog2(LEN + 1);
   localparam int CW = $clog2(N);
   localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, EMIT = 2'd2;
   logic [1:0]       state;
   logic             ovf, neg, done_q;
   logic [N:0]       sh, mag;
   logic [4*DIG-1:0] bcd, adj, bcd_nx;
   logic [4*DIG+3:0] bcd_p;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    ptr, len, nd;
   logic [3:0]       nib;
   logic [7:0]       ch;
   logic [8*LEN-1:0] str_q;
   logic             hs;
   // N+1 bits so that the most negative input still has a representable magnitude
   assign mag = bus.value[N-1] ? -{bus.value[N-1], bus.value} : {bus.value[N-1], bus.value};
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIG; i++)
         adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      bcd_nx = {adj[4*DIG-2:0], sh[N-1]};
   end
   always_comb begin
      nd = PW'(1);
      for (int i = 1; i < DIG; i++)
         if (bcd[4*i +: 4] != 4'd0) nd = PW'(i + 1);
   end
   // spare zero nibble keeps the digit select in range while '-' is being presented
   assign bcd_p = {4'd0, bcd};
   always_comb begin
      nib = bcd_p[4*(int'(nd) - 1 - int'(ptr) + int'(neg)) +: 4];
      ch = ovf ? (ptr == PW'(0) ? "O" : ptr == PW'(1) ? "V" : "F") :
           (neg && ptr == PW'(0)) ? "-" : 8'h30 + {4'd0, nib};
   end
   assign len          = ovf ? PW'(3) : nd + PW'(neg);
   assign bus.busy     = state != IDLE;
   assign bus.tx_valid = state == EMIT;
   assign bus.tx_last  = bus.tx_valid && ptr == len - PW'(1);
   assign bus.tx_data  = bus.tx_valid ? ch : 8'h00;
   assign bus.str      = str_q;
   assign bus.done     = done_q;
   assign hs           = bus.tx_valid && bus.tx_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ovf    <= 1'b0;
         neg    <= 1'b0;
         sh     <= '0;
         bcd    <= '0;
         cnt    <= '0;
         ptr    <= '0;
         str_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            if (bus.start) begin
               ovf   <= bus.ovf_in;
               neg   <= bus.value[N-1];
               sh    <= mag;
               bcd   <= '0;
               cnt   <= '0;
               ptr   <= '0;
               str_q <= '0;
               state <= bus.ovf_in ? EMIT : CONV;
            end
         end else if (state == CONV) begin
            bcd   <= bcd_nx;
            sh    <= {sh[N-1:0], 1'b0};
            cnt   <= cnt + CW'(1);
            state <= cnt == CW'(N - 1) ? EMIT : CONV;
         end else if (hs) begin
            str_q[8*(LEN-1-int'(ptr)) +: 8] <= bus.tx_data;
            ptr <= ptr + PW'(1);
            if (bus.tx_last) begin
               state  <= IDLE;
               done_q <= 1'b1;
            end
         end
      end
   end
endmodule
